// File: rtl/mips_mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcodes,
// funct codes, ALU codes, datapath mux selects and the control-word layout.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EX   = 4'd9,
        S_IMMWB    = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    // Which rule selects the ALU operation in a given state.
    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_RTYPE = 2'd2,
        CLS_IMM   = 2'd3
    } alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SRL = 6'b000010;

    localparam logic [2:0] ALU_AND   = 3'b000;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_XOR   = 3'b011;
    localparam logic [2:0] ALU_SRL   = 3'b100;
    localparam logic [2:0] ALU_ORNOT = 3'b101;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_SLT   = 3'b111;

    localparam logic [1:0] ASA_PC    = 2'b00;
    localparam logic [1:0] ASA_REGA  = 2'b01;
    localparam logic [1:0] ASA_SHAMT = 2'b10;

    localparam logic [1:0] ASB_REGB  = 2'b00;
    localparam logic [1:0] ASB_FOUR  = 2'b01;
    localparam logic [1:0] ASB_IMM   = 2'b10;
    localparam logic [1:0] ASB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       memwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic [2:0] alucont;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c = '0;
        c.alucont = ALU_ADD;
        return c;
    endfunction

    function automatic ctrl_t ctrl_fetch();
        ctrl_t c;
        c = ctrl_idle();
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
        c.alusrcb = ASB_FOUR;
        return c;
    endfunction

    function automatic alu_class_e state_class(input state_e s);
        case (s)
            S_BRANCH:   return CLS_SUB;
            S_RTYPE_EX: return CLS_RTYPE;
            S_IMM_EX:   return CLS_IMM;
            default:    return CLS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mips_mc_controller_alu_decoder.sv
// Combinational ALU operation decode: picks the ALU code for the current
// state class and flags supported R-type functs and the srl shamt operand.
module alu_decoder
    import mips_mc_pkg::*;
(
    input  alu_class_e  cls_i,
    input  logic [5:0]  op_i,
    input  logic [5:0]  funct_i,
    output logic [2:0]  alucont_o,
    output logic        funct_valid_o,
    output logic        shamt_sel_o
);

    always_comb begin
        funct_valid_o = 1'b0;
        case (funct_i)
            FN_ADD, FN_SUB, FN_AND, FN_OR,
            FN_XOR, FN_SLT, FN_SRL: funct_valid_o = 1'b1;
            default:                funct_valid_o = 1'b0;
        endcase
    end

    always_comb begin
        alucont_o   = ALU_ADD;
        shamt_sel_o = 1'b0;
        case (cls_i)
            CLS_SUB: alucont_o = ALU_SUB;
            CLS_RTYPE: begin
                case (funct_i)
                    FN_ADD: alucont_o = ALU_ADD;
                    FN_SUB: alucont_o = ALU_SUB;
                    FN_AND: alucont_o = ALU_AND;
                    FN_OR:  alucont_o = ALU_OR;
                    FN_XOR: alucont_o = ALU_XOR;
                    FN_SLT: alucont_o = ALU_SLT;
                    FN_SRL: begin
                        alucont_o   = ALU_SRL;
                        shamt_sel_o = 1'b1;
                    end
                    default: alucont_o = ALU_ADD;
                endcase
            end
            CLS_IMM: begin
                case (op_i)
                    OP_ANDI: alucont_o = ALU_AND;
                    OP_ORI:  alucont_o = ALU_OR;
                    default: alucont_o = ALU_ADD;
                endcase
            end
            default: alucont_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/
// memory/writeback with registered datapath controls; only pcen is combinational.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic       extop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucont
);

    state_e     state_q, state_d;
    ctrl_t      ctl_q, ctl_d;
    logic [2:0] dec_alucont;
    logic       dec_funct_valid;
    logic       dec_shamt_sel;

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:            state_d = S_MEMADR;
                    OP_RTYPE:                state_d = S_RTYPE_EX;
                    OP_BEQ, OP_BNE:          state_d = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: state_d = S_IMM_EX;
                    OP_J:                    state_d = S_JUMP;
                    default:                 state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    state_d = S_MEMWB;
            S_RTYPE_EX: state_d = S_ALUWB;
            S_IMM_EX:   state_d = S_IMMWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // The decoder looks at the state being entered, so the control word can be
    // registered alongside the state; the IR holds op/funct across the instruction.
    alu_decoder u_alu_decoder (
        .cls_i         (state_class(state_d)),
        .op_i          (op),
        .funct_i       (funct),
        .alucont_o     (dec_alucont),
        .funct_valid_o (dec_funct_valid),
        .shamt_sel_o   (dec_shamt_sel)
    );

    always_comb begin
        ctl_d         = ctrl_idle();
        ctl_d.alucont = dec_alucont;
        case (state_d)
            S_FETCH: ctl_d = ctrl_fetch();
            S_DECODE: begin
                ctl_d.alusrcb = ASB_IMMSH;
                ctl_d.extop   = 1'b1;
            end
            S_MEMADR: begin
                ctl_d.alusrca = ASA_REGA;
                ctl_d.alusrcb = ASB_IMM;
                ctl_d.extop   = 1'b1;
            end
            S_MEMRD: ctl_d.iord = 1'b1;
            S_MEMWB: begin
                ctl_d.regwrite = 1'b1;
                ctl_d.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctl_d.iord     = 1'b1;
                ctl_d.memwrite = 1'b1;
            end
            S_RTYPE_EX: ctl_d.alusrca = dec_shamt_sel ? ASA_SHAMT : ASA_REGA;
            S_ALUWB: begin
                ctl_d.regdst   = 1'b1;
                ctl_d.regwrite = dec_funct_valid;
            end
            S_BRANCH: begin
                ctl_d.alusrca = ASA_REGA;
                ctl_d.pcsrc   = PCS_ALUOUT;
            end
            S_IMM_EX: begin
                ctl_d.alusrca = ASA_REGA;
                ctl_d.alusrcb = ASB_IMM;
                ctl_d.extop   = (op == OP_ADDI);
            end
            S_IMMWB: ctl_d.regwrite = 1'b1;
            S_JUMP: begin
                ctl_d.pcsrc   = PCS_JUMP;
                ctl_d.pcwrite = 1'b1;
            end
            default: ctl_d = ctrl_idle();
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ctl_q   <= ctrl_fetch();
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    assign irwrite  = ctl_q.irwrite;
    assign memwrite = ctl_q.memwrite;
    assign regwrite = ctl_q.regwrite;
    assign iord     = ctl_q.iord;
    assign regdst   = ctl_q.regdst;
    assign memtoreg = ctl_q.memtoreg;
    assign alusrca  = ctl_q.alusrca;
    assign alusrcb  = ctl_q.alusrcb;
    assign extop    = ctl_q.extop;
    assign pcsrc    = ctl_q.pcsrc;
    assign alucont  = ctl_q.alucont;

    // Branch resolution uses the ALU zero flag produced in the BRANCH cycle itself.
    assign pcen = ctl_q.pcwrite |
                  ((state_q == S_BRANCH) & (zero ^ (op == OP_BNE)));

endmodule
